// File: rtl/crossbar4_pkg.sv
// Shared constants, output-FSM state type and the round-robin picker
// used by the 4x4 crossbar request arbiter.
package crossbar4_pkg;

    localparam int N_PORTS = 4;
    localparam int PORT_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // First set bit of cand in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // Later loop iterations override earlier ones, so the nearest candidate wins.
    function automatic logic [PORT_W-1:0] rr_pick(input logic [N_PORTS-1:0] cand,
                                                  input logic [PORT_W-1:0]  ptr);
        logic [PORT_W-1:0] idx;
        rr_pick = ptr;
        for (int k = N_PORTS; k >= 1; k--) begin
            idx = ptr + PORT_W'(k);
            if (cand[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/crossbar4_out_arbiter.sv
// One crossbar output: IDLE/GRANT/RELEASE FSM with round-robin pointer
// and saturating hold counter. All outputs are flops.
module crossbar4_out_arbiter
    import crossbar4_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input  logic                clk,
    input  logic                hard_reset,
    input  logic [N_PORTS-1:0]  cand,
    input  logic [N_PORTS-1:0]  req,
    output logic                busy,
    output logic [PORT_W-1:0]   sel,
    output logic [N_PORTS-1:0]  ack,
    output logic [N_PORTS-1:0]  timeout,
    output arb_state_e          state
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_e          state_q, state_d;
    logic [PORT_W-1:0]   owner_q, owner_d;
    logic [PORT_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [PORT_W-1:0]   sel_q, sel_d;
    logic [N_PORTS-1:0]  ack_q, ack_d;
    logic [N_PORTS-1:0]  timeout_q, timeout_d;
    logic [PORT_W-1:0]   pick;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = '0;
        pick      = rr_pick(cand, ptr_q);
        case (state_q)
            // RELEASE is the one dead cycle; arbitration may grant at its closing edge.
            IDLE, RELEASE: begin
                state_d = IDLE;
                if (|cand) begin
                    state_d = GRANT;
                    owner_d = pick;
                    ptr_d   = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                if (!req[owner_q]) begin
                    state_d = RELEASE;
                end else if (HOLD_EN && cnt_q == HOLD_LAST) begin
                    state_d              = RELEASE;
                    timeout_d[owner_q]   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == GRANT);
        sel_d  = busy_d ? owner_d : '0;
        ack_d  = '0;
        if (busy_d) ack_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= PORT_W'(N_PORTS - 1);
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            sel_q     <= '0;
            ack_q     <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            sel_q     <= sel_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = busy_q;
    assign sel     = sel_q;
    assign ack     = ack_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: rtl/crossbar4_arbiter.sv
// 4x4 crossbar request arbiter: builds per-output candidate vectors, tracks
// timeout blocking per input and merges the four output arbiters.
module crossbar4_arbiter
    import crossbar4_pkg::*;
#(
    parameter int MAX_HOLD = 64
) (
    input  logic                        clk,
    input  logic                        hard_reset,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS*PORT_W-1:0]   dest,
    output logic [N_PORTS-1:0]          ack,
    output logic [N_PORTS-1:0]          out_busy,
    output logic [N_PORTS*PORT_W-1:0]   out_sel,
    output logic [N_PORTS-1:0]          timeout,
    output logic [N_PORTS*PORT_W-1:0]   dbg_state
);

    logic [N_PORTS-1:0]  cand      [N_PORTS];
    logic [N_PORTS-1:0]  ack_j     [N_PORTS];
    logic [N_PORTS-1:0]  timeout_j [N_PORTS];
    logic [PORT_W-1:0]   sel_j     [N_PORTS];
    logic                busy_j    [N_PORTS];
    arb_state_e          state_j   [N_PORTS];
    logic [N_PORTS-1:0]  blocked_q, blocked_d;

    // timeout is the registered pulse, so it also blocks during the cycle before blocked_q catches up.
    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            cand[j] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                cand[j][i] = req[i] && (dest[PORT_W*i +: PORT_W] == PORT_W'(j))
                             && !ack[i] && !blocked_q[i] && !timeout[i];
            end
        end
    end

    always_comb begin
        blocked_d = req & (blocked_q | timeout);
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            blocked_q <= '0;
        end else begin
            blocked_q <= blocked_d;
        end
    end

    for (genvar j = 0; j < N_PORTS; j++) begin : g_out
        crossbar4_out_arbiter #(
            .MAX_HOLD (MAX_HOLD)
        ) u_arb (
            .clk        (clk),
            .hard_reset (hard_reset),
            .cand       (cand[j]),
            .req        (req),
            .busy       (busy_j[j]),
            .sel        (sel_j[j]),
            .ack        (ack_j[j]),
            .timeout    (timeout_j[j]),
            .state      (state_j[j])
        );
    end

    // Each input targets one output, so the per-output one-hots never overlap.
    always_comb begin
        ack       = '0;
        timeout   = '0;
        out_busy  = '0;
        out_sel   = '0;
        dbg_state = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            ack                          = ack | ack_j[j];
            timeout                      = timeout | timeout_j[j];
            out_busy[j]                  = busy_j[j];
            out_sel[PORT_W*j +: PORT_W]  = sel_j[j];
            dbg_state[PORT_W*j +: PORT_W] = state_j[j];
        end
    end

endmodule

// File: tb/tb_crossbar4_arbiter.sv
// Self-checking bench for crossbar4_arbiter: directed vector tables, a
// contention sequence, and random traffic against a behavioural model.
module tb_crossbar4_arbiter;

    localparam int MH = 8;
    localparam int W  = 20;

    typedef struct {
        logic [3:0] req;
        logic [7:0] dest;
        logic [3:0] ack;
        logic [3:0] busy;
        logic [7:0] sel;
        logic [3:0] to;
    } vec_t;

    logic       clk = 1'b0;
    logic       hard_reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] dest = 8'h00;
    logic [3:0] ack, out_busy, timeout;
    logic [7:0] out_sel, dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    // model state: owner per output (-1 = free), cycles held, last grantee, blocked inputs
    int       m_own  [4];
    int       m_held [4];
    int       m_last [4];
    bit       m_blk  [4];
    logic [3:0] m_to;
    bit       started = 0;

    vec_t dir_v [10];
    vec_t rr_v  [9];
    vec_t to_v  [17];

    crossbar4_arbiter #(.MAX_HOLD(MH)) dut (
        .clk        (clk),
        .hard_reset (hard_reset),
        .req        (req),
        .dest       (dest),
        .ack        (ack),
        .out_busy   (out_busy),
        .out_sel    (out_sel),
        .timeout    (timeout),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [7:0] d, input logic [3:0] a,
                                input logic [3:0] b, input logic [7:0] s, input logic [3:0] t);
        vec_t v;
        v.req = r; v.dest = d; v.ack = a; v.busy = b; v.sel = s; v.to = t;
        return v;
    endfunction

    // Reference model: one step per rising edge, using pre-edge ownership for all decisions.
    function automatic void model_step(input logic rst, input logic [3:0] r, input logic [7:0] d);
        int  pre_own [4];
        bit  new_blk [4];
        bit  owns;
        int  o, i;
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                m_own[j] = -1; m_held[j] = 0; m_last[j] = 3; m_blk[j] = 0;
            end
            m_to = 4'b0000;
            return;
        end
        m_to = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            pre_own[j] = m_own[j];
            new_blk[j] = m_blk[j];
        end
        for (int j = 0; j < 4; j++) begin
            if (pre_own[j] >= 0) begin
                o = pre_own[j];
                if (!r[o]) begin
                    m_own[j] = -1;
                end else if (MH != 0 && m_held[j] == MH) begin
                    m_own[j] = -1;
                    m_to[o] = 1'b1;
                    new_blk[o] = 1;
                end else begin
                    m_held[j]++;
                end
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    i = (m_last[j] + k) % 4;
                    owns = 0;
                    for (int jj = 0; jj < 4; jj++) if (pre_own[jj] == i) owns = 1;
                    if (r[i] && d[2*i +: 2] == j && !owns && !m_blk[i]) begin
                        m_own[j] = i; m_held[j] = 1; m_last[j] = i;
                        break;
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) m_blk[j] = r[j] ? new_blk[j] : 0;
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [3:0] a, b;
        logic [7:0] s;
        a = 0; b = 0; s = 0;
        for (int j = 0; j < 4; j++) begin
            if (m_own[j] >= 0) begin
                a[m_own[j]] = 1'b1;
                b[j] = 1'b1;
                s[2*j +: 2] = 2'(m_own[j]);
            end
        end
        return {a, b, s, m_to};
    endfunction

    // Scoreboard: model prediction per edge, compared 1 time unit after the edge.
    always @(posedge clk) begin
        logic [W-1:0] e;
        model_step(hard_reset, req, dest);
        if (hard_reset) started = 1;
        if (started) exp_q.push_back(model_out());
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model", {ack, out_busy, out_sel, timeout}, e);
        end
    end

    task automatic do_reset(input int n, input logic [3:0] r, input logic [7:0] d, input bit chk);
        @(negedge clk);
        hard_reset = 1'b1; req = r; dest = d;
        repeat (n) begin
            @(posedge clk); #2;
            if (chk) begin
                check("reset_ack", ack, 4'b0000);
                check("reset_busy", out_busy, 4'b0000);
                check("reset_timeout", timeout, 4'b0000);
            end
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        @(negedge clk);
        hard_reset = 1'b0; req = v.req; dest = v.dest;
        @(posedge clk); #2;
        check({name, "_ack"}, ack, v.ack);
        check({name, "_busy"}, out_busy, v.busy);
        check({name, "_sel"}, out_sel, v.sel);
        check({name, "_to"}, timeout, v.to);
    endtask

    initial begin
        // reset release, single request, parallel connections
        dir_v[0] = mk(4'b1111, 8'h00, 4'b0001, 4'b0001, 8'h00, 4'b0000);
        dir_v[1] = mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        dir_v[2] = mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        dir_v[3] = mk(4'b0001, 8'h02, 4'b0001, 4'b0100, 8'h00, 4'b0000);
        dir_v[4] = mk(4'b0001, 8'h02, 4'b0001, 4'b0100, 8'h00, 4'b0000);
        dir_v[5] = mk(4'b0000, 8'h02, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        dir_v[6] = mk(4'b0000, 8'h02, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        dir_v[7] = mk(4'b1111, 8'h1B, 4'b1111, 4'b1111, 8'h1B, 4'b0000);
        dir_v[8] = mk(4'b0000, 8'h1B, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        dir_v[9] = mk(4'b0000, 8'h1B, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        // round-robin on output 0: 3 owns, then 0, then 2
        rr_v[0] = mk(4'b1000, 8'h00, 4'b1000, 4'b0001, 8'h03, 4'b0000);
        rr_v[1] = mk(4'b1101, 8'h00, 4'b1000, 4'b0001, 8'h03, 4'b0000);
        rr_v[2] = mk(4'b1101, 8'h00, 4'b1000, 4'b0001, 8'h03, 4'b0000);
        rr_v[3] = mk(4'b0101, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        rr_v[4] = mk(4'b0101, 8'h00, 4'b0001, 4'b0001, 8'h00, 4'b0000);
        rr_v[5] = mk(4'b0101, 8'h00, 4'b0001, 4'b0001, 8'h00, 4'b0000);
        rr_v[6] = mk(4'b0100, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        rr_v[7] = mk(4'b0100, 8'h00, 4'b0100, 4'b0001, 8'h02, 4'b0000);
        rr_v[8] = mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        // timeout: input 1 holds output 0 for MH=8 cycles while input 2 waits
        to_v[0] = mk(4'b0010, 8'h00, 4'b0010, 4'b0001, 8'h01, 4'b0000);
        for (int t = 1; t <= 7; t++) to_v[t] = mk(4'b0110, 8'h00, 4'b0010, 4'b0001, 8'h01, 4'b0000);
        to_v[8]  = mk(4'b0110, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0010);
        to_v[9]  = mk(4'b0110, 8'h00, 4'b0100, 4'b0001, 8'h02, 4'b0000);
        to_v[10] = mk(4'b0110, 8'h00, 4'b0100, 4'b0001, 8'h02, 4'b0000);
        to_v[11] = mk(4'b0110, 8'h00, 4'b0100, 4'b0001, 8'h02, 4'b0000);
        to_v[12] = mk(4'b0010, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        to_v[13] = mk(4'b0010, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        to_v[14] = mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);
        to_v[15] = mk(4'b0010, 8'h00, 4'b0010, 4'b0001, 8'h01, 4'b0000);
        to_v[16] = mk(4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 4'b0000);

        do_reset(4, 4'b1111, 8'h00, 1);
        for (int v = 0; v < 10; v++) run_vec("dir", dir_v[v]);

        do_reset(2, 4'b0000, 8'h00, 0);
        for (int v = 0; v < 9; v++) run_vec("rr", rr_v[v]);

        do_reset(2, 4'b0000, 8'h00, 0);
        for (int v = 0; v < 17; v++) run_vec("timeout", to_v[v]);

        // contention: all request output 1; input k granted at t=4k, drops so req is low at t=4k+3
        do_reset(2, 4'b0000, 8'h55, 0);
        for (int t = 0; t < 16; t++) begin
            logic [3:0] ea;
            logic [1:0] es;
            @(negedge clk);
            hard_reset = 1'b0;
            dest = 8'h55;
            for (int k = 0; k < 4; k++) req[k] = (t <= 4*k + 2);
            @(posedge clk); #2;
            ea = (t % 4 == 3) ? 4'b0000 : 4'(1 << (t / 4));
            es = (t % 4 == 3) ? 2'd0 : 2'(t / 4);
            check("contention_ack", ack, ea);
            check("contention_busy", out_busy, (t % 4 == 3) ? 4'b0000 : 4'b0010);
            check("contention_sel", out_sel[3:2], es);
        end

        // random traffic, dest held stable while req is high, occasional mid-run reset
        do_reset(2, 4'b0000, 8'h00, 0);
        @(negedge clk);
        hard_reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hard_reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        dest[2*i +: 2] = 2'($urandom_range(0, 3));
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 11) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        hard_reset = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
